// File: rtl/cadr_pkg.sv
// Shared CADR definitions: VMA/memory sequencer states and default timing.
package cadr_pkg;

    typedef enum logic [1:0] {
        VMA_IDLE  = 2'd0,
        VMA_SPY   = 2'd1,
        VMA_START = 2'd2,
        VMA_WAIT  = 2'd3
    } vma_state_e;

    localparam int TIMEOUT_DEF = 64;
    localparam int TW_DEF      = 7;

endpackage

// File: rtl/vma_ctl.sv
// VMA load arbitration (microcode vs. spy) and main-memory cycle sequencing
// with a non-existent-memory timeout.
module vma_ctl
    import cadr_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic state_alu,
    input  logic vmaenb,
    input  logic memrq_rd,
    input  logic memrq_wr,
    input  logic spy_req,
    input  logic spy_sel,
    input  logic mem_ack,
    output logic vma_load,
    output logic ldvmal,
    output logic ldvmah,
    output logic spy_ack,
    output logic mem_start,
    output logic mem_wr,
    output logic mem_busy,
    output logic mem_nxm,
    output logic stall
);

    vma_state_e    state_r;
    logic [TW-1:0] cnt_r;
    logic          ldvmal_r;
    logic          ldvmah_r;
    logic          spy_ack_r;
    logic          mem_start_r;
    logic          mem_wr_r;
    logic          mem_nxm_r;
    logic          ucreq_s;
    logic          memrq_s;
    logic          stall_s;

    assign memrq_s  = state_alu & (memrq_rd | memrq_wr);
    assign ucreq_s  = state_alu & (vmaenb | memrq_rd | memrq_wr);
    // Any microcode request is held off while VMA belongs to a spy or memory cycle.
    assign stall_s  = ucreq_s & (state_r != VMA_IDLE);

    assign stall     = stall_s;
    assign vma_load  = state_alu & vmaenb & ~stall_s;
    assign ldvmal    = ldvmal_r;
    assign ldvmah    = ldvmah_r;
    assign spy_ack   = spy_ack_r;
    assign mem_start = mem_start_r;
    assign mem_wr    = mem_wr_r;
    assign mem_nxm   = mem_nxm_r;
    assign mem_busy  = (state_r == VMA_START) | (state_r == VMA_WAIT);

    // Sequencer: state, timeout counter and all registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= VMA_IDLE;
            cnt_r       <= {TW{1'b0}};
            ldvmal_r    <= 1'b0;
            ldvmah_r    <= 1'b0;
            spy_ack_r   <= 1'b0;
            mem_start_r <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_nxm_r   <= 1'b0;
        end else begin
            ldvmal_r    <= 1'b0;
            ldvmah_r    <= 1'b0;
            spy_ack_r   <= 1'b0;
            mem_start_r <= 1'b0;
            mem_nxm_r   <= 1'b0;
            case (state_r)
                VMA_IDLE: begin
                    // Microcode outranks spy; write wins when both directions are requested.
                    if (memrq_s) begin
                        state_r     <= VMA_START;
                        mem_wr_r    <= memrq_wr;
                        mem_start_r <= 1'b1;
                    end else if (spy_req & ~ucreq_s) begin
                        state_r   <= VMA_SPY;
                        ldvmah_r  <= spy_sel;
                        ldvmal_r  <= ~spy_sel;
                        spy_ack_r <= 1'b1;
                    end else begin
                        state_r <= VMA_IDLE;
                    end
                end
                VMA_SPY: begin
                    state_r <= VMA_IDLE;
                end
                VMA_START: begin
                    cnt_r   <= {TW{1'b0}};
                    state_r <= VMA_WAIT;
                end
                VMA_WAIT: begin
                    if (mem_ack) begin
                        state_r <= VMA_IDLE;
                    end else if (cnt_r == TW'(TIMEOUT - 1)) begin
                        mem_nxm_r <= 1'b1;
                        state_r   <= VMA_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= VMA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vma_ctl.sv
// Cycle-accurate scoreboard bench for vma_ctl with TIMEOUT shortened to 4.
module tb_vma_ctl;

    // input vector bits: {reset, state_alu, vmaenb, memrq_rd, memrq_wr, spy_req, spy_sel, mem_ack}
    localparam logic [7:0] I_RST = 8'h80;
    localparam logic [7:0] I_SA  = 8'h40;
    localparam logic [7:0] I_VE  = 8'h20;
    localparam logic [7:0] I_RD  = 8'h10;
    localparam logic [7:0] I_WR  = 8'h08;
    localparam logic [7:0] I_SQ  = 8'h04;
    localparam logic [7:0] I_SS  = 8'h02;
    localparam logic [7:0] I_AK  = 8'h01;
    localparam logic [7:0] I_NONE = 8'h00;

    // output vector bits: {vma_load, ldvmal, ldvmah, spy_ack, mem_start, mem_wr, mem_busy, mem_nxm, stall}
    localparam logic [8:0] O_VL = 9'h100;
    localparam logic [8:0] O_LL = 9'h080;
    localparam logic [8:0] O_LH = 9'h040;
    localparam logic [8:0] O_SA = 9'h020;
    localparam logic [8:0] O_MS = 9'h010;
    localparam logic [8:0] O_MW = 9'h008;
    localparam logic [8:0] O_MB = 9'h004;
    localparam logic [8:0] O_NX = 9'h002;
    localparam logic [8:0] O_ST = 9'h001;
    localparam logic [8:0] O_NONE = 9'h000;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset, state_alu, vmaenb, memrq_rd, memrq_wr, spy_req, spy_sel, mem_ack;
    logic vma_load, ldvmal, ldvmah, spy_ack, mem_start, mem_wr, mem_busy, mem_nxm, stall;
    logic [8:0] obs;

    int checks = 0;
    int failures = 0;
    sb_entry_t sb_q[$];

    vma_ctl #(.TIMEOUT(4), .TW(3)) dut (
        .clk(clk), .reset(reset), .state_alu(state_alu), .vmaenb(vmaenb),
        .memrq_rd(memrq_rd), .memrq_wr(memrq_wr), .spy_req(spy_req),
        .spy_sel(spy_sel), .mem_ack(mem_ack), .vma_load(vma_load),
        .ldvmal(ldvmal), .ldvmah(ldvmah), .spy_ack(spy_ack),
        .mem_start(mem_start), .mem_wr(mem_wr), .mem_busy(mem_busy),
        .mem_nxm(mem_nxm), .stall(stall)
    );

    always #5 clk = ~clk;

    assign obs = {vma_load, ldvmal, ldvmah, spy_ack, mem_start, mem_wr, mem_busy, mem_nxm, stall};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] in_v, input logic [8:0] exp);
        sb_entry_t e;
        {reset, state_alu, vmaenb, memrq_rd, memrq_wr, spy_req, spy_sel, mem_ack} = in_v;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs mid-cycle against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check_eq(e.tag, {23'd0, obs}, {23'd0, e.exp});
        end
    end

    initial begin
        {reset, state_alu, vmaenb, memrq_rd, memrq_wr, spy_req, spy_sel, mem_ack} = 8'hFF;
        @(posedge clk);
        #1;

        // reset with every input high: only the combinational load may show
        step("rst1", 8'hFF, O_VL);
        step("rst2", 8'hFF, O_VL);
        step("idle0", I_NONE, O_NONE);

        // read cycle, ack on the fourth busy cycle
        step("rd_req",   I_SA | I_VE | I_RD, O_VL);
        step("rd_start", I_NONE, O_MS | O_MB);
        step("rd_wait0", I_NONE, O_MB);
        step("rd_wait1", I_NONE, O_MB);
        step("rd_ack",   I_AK, O_MB);
        step("rd_idle",  I_NONE, O_NONE);

        // write cycle with microcode VMA loads stalled in WAIT
        step("wr_req",    I_SA | I_WR, O_NONE);
        step("wr_start",  I_NONE, O_MS | O_MW | O_MB);
        step("st_wait0",  I_SA | I_VE, O_MW | O_MB | O_ST);
        step("st_wait1",  I_SA | I_VE, O_MW | O_MB | O_ST);
        step("st_ackreq", I_SA | I_VE | I_AK, O_MW | O_MB | O_ST);
        step("st_accept", I_SA | I_VE, O_VL | O_MW);
        step("st_idle",   I_NONE, O_MW);

        // spy high half waits behind microcode, then loads
        step("spy_blk0", I_SA | I_VE | I_SQ | I_SS, O_VL | O_MW);
        step("spy_blk1", I_SA | I_VE | I_SQ | I_SS, O_VL | O_MW);
        step("spy_acc",  I_SQ | I_SS, O_MW);
        step("spy_hi",   I_SQ | I_SS, O_LH | O_SA | O_MW);
        step("spy_done", I_NONE, O_MW);
        // spy low half, microcode stalled during the SPY cycle
        step("spyl_acc", I_SQ, O_MW);
        step("spyl_lo",  I_SA | I_VE, O_LL | O_SA | O_MW | O_ST);
        step("spyl_idl", I_NONE, O_MW);

        // reset in the middle of WAIT abandons the cycle
        step("mr_req",   I_SA | I_RD, O_MW);
        step("mr_start", I_NONE, O_MS | O_MB);
        step("mr_wait",  I_NONE, O_MB);
        step("mr_rst",   I_RST, O_MB);
        step("mr_late",  I_AK, O_NONE);
        step("mr_idle",  I_NONE, O_NONE);
        step("mr2_req",  I_SA | I_VE | I_RD, O_VL);
        step("mr2_strt", I_NONE, O_MS | O_MB);
        step("mr2_ack",  I_AK, O_MB);
        step("mr2_idle", I_NONE, O_NONE);

        // timeout: both directions (write wins), no ack
        step("to_req",   I_SA | I_RD | I_WR, O_NONE);
        step("to_start", I_SA | I_VE, O_MS | O_MW | O_MB | O_ST);
        step("to_w0",    I_NONE, O_MW | O_MB);
        step("to_w1",    I_NONE, O_MW | O_MB);
        step("to_w2",    I_NONE, O_MW | O_MB);
        step("to_w3",    I_NONE, O_MW | O_MB);
        step("to_nxm",   I_NONE, O_NX | O_MW);
        step("to_idle",  I_NONE, O_MW);
        step("to_lateak", I_AK, O_MW);
        step("to_after", I_NONE, O_MW);

        @(negedge clk);
        #1;
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
